// File: rtl/sd_wb_byte_aligner.sv
// Repacks big-endian memory words, fetched from a possibly unaligned byte address,
// into contiguous MSB-aligned 32-bit words covering exactly the transfer window.
module sd_wb_byte_aligner #(
    parameter int XFER_W = 28
) (
    input  logic              wb_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_adr_i,
    input  logic [XFER_W-1:0] xfersize,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic [2:0]        out_bytes,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        off;
    logic              first;
    logic [XFER_W-1:0] rem;
    logic [XFER_W:0]   words;
    logic [23:0]       acc;
    logic [1:0]        acc_cnt;

    logic              out_free;
    logic              accept;
    logic              final_word;
    logic [1:0]        lane_start;
    logic [2:0]        avail;
    logic [2:0]        n;
    logic [2:0]        total;
    logic [31:0]       shifted;
    logic [31:0]       clipped;
    logic [55:0]       merged;
    logic [XFER_W+1:0] span;
    logic [XFER_W:0]   words_init;
    logic              unused_bits;

    // Keeps the top nb byte lanes of a word.
    function automatic logic [31:0] lane_mask(input logic [2:0] nb);
        case (nb)
            3'd1:    lane_mask = 32'hFF00_0000;
            3'd2:    lane_mask = 32'hFFFF_0000;
            3'd3:    lane_mask = 32'hFFFF_FF00;
            3'd4:    lane_mask = 32'hFFFF_FFFF;
            default: lane_mask = 32'h0000_0000;
        endcase
    endfunction

    // Clips the lanes a word offers to the bytes still owed to the transfer.
    function automatic logic [2:0] clip_count(input logic [2:0] offered,
                                              input logic [XFER_W-1:0] left);
        if (left < XFER_W'(offered))
            clip_count = left[2:0];
        else
            clip_count = offered;
    endfunction

    assign span        = (XFER_W+2)'(xfersize) + (XFER_W+2)'(base_adr_i[1:0]) + (XFER_W+2)'(3);
    assign words_init  = (XFER_W+1)'(span[XFER_W+1:2]);
    assign unused_bits = ^{base_adr_i[31:2], span[1:0]};

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = (state == S_RUN) && (words != '0) && out_free;
    assign accept     = in_valid && in_ready;
    assign final_word = (words == (XFER_W+1)'(1));

    // Align the window's first lane to the MSB, then append behind the held bytes.
    assign lane_start = first ? off : 2'd0;
    assign avail      = 3'd4 - {1'b0, lane_start};
    assign n          = clip_count(avail, rem);
    assign shifted    = in_data << {lane_start, 3'b000};
    assign clipped    = shifted & lane_mask(n);
    assign merged     = {acc, 32'h0} | ({clipped, 24'h0} >> {acc_cnt, 3'b000});
    assign total      = {1'b0, acc_cnt} + n;

    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (xfersize == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (accept && final_word)
                    state_nxt = (total > 3'd4) ? S_FLUSH : S_WAIT;
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (out_free)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst) begin
            off       <= 2'd0;
            first     <= 1'b0;
            rem       <= '0;
            words     <= '0;
            acc       <= 24'h0;
            acc_cnt   <= 2'd0;
            out_data  <= 32'h0;
            out_bytes <= 3'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // A consumed word empties the register unless a reload below refills it.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        off     <= base_adr_i[1:0];
                        rem     <= xfersize;
                        words   <= words_init;
                        first   <= 1'b1;
                        acc     <= 24'h0;
                        acc_cnt <= 2'd0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        first <= 1'b0;
                        rem   <= rem - XFER_W'(n);
                        words <= words - (XFER_W+1)'(1);
                        if (total >= 3'd4) begin
                            out_data  <= merged[55:24];
                            out_bytes <= 3'd4;
                            out_last  <= final_word && (total == 3'd4);
                            out_valid <= 1'b1;
                            acc       <= merged[23:0];
                            acc_cnt   <= 2'(total - 3'd4);
                        end else if (final_word) begin
                            out_data  <= merged[55:24];
                            out_bytes <= total;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                            acc       <= 24'h0;
                            acc_cnt   <= 2'd0;
                        end else begin
                            acc     <= merged[55:32];
                            acc_cnt <= total[1:0];
                        end
                    end
                end
                S_FLUSH: begin
                    if (out_free) begin
                        out_data  <= {acc, 8'h00};
                        out_bytes <= {1'b0, acc_cnt};
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        acc       <= 24'h0;
                        acc_cnt   <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_wb_byte_aligner.sv
// Directed bench for sd_wb_byte_aligner: aligned, unaligned, multi-word, backpressure,
// zero-length and mid-transfer reset cases with hand-computed expected words.
module tb_sd_wb_byte_aligner;
    localparam int XW = 28;

    logic          wb_clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   base_adr_i;
    logic [XW-1:0] xfersize;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   out_data;
    logic [2:0]    out_bytes;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] in_words[$];
    logic [31:0] exp_d[$];
    logic [2:0]  exp_b[$];
    logic        exp_l[$];

    sd_wb_byte_aligner #(.XFER_W(XW)) dut (
        .wb_clk     (wb_clk),
        .rst        (rst),
        .start      (start),
        .base_adr_i (base_adr_i),
        .xfersize   (xfersize),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input string tn, input logic [31:0] base, input int size,
                            input int exp_in, input int stall);
        int  in_idx     = 0;
        int  out_idx    = 0;
        int  done_cnt   = 0;
        int  cyc        = 0;
        int  stall_left = stall;
        bit  fin        = 0;
        @(negedge wb_clk);
        start      = 1'b1;
        base_adr_i = base;
        xfersize   = XW'(size);
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        while (!fin && cyc < 300) begin
            in_valid = (in_idx < in_words.size());
            in_data  = in_valid ? in_words[in_idx] : 32'h0;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) begin
                chk({tn, "_hold_data"}, out_data, exp_d[0]);
                chk({tn, "_hold_in_ready"}, {31'h0, in_ready}, 32'h0);
            end
            if (done) begin
                done_cnt++;
                fin = 1;
            end
            if (in_valid && in_ready)
                in_idx++;
            if (out_valid && out_ready) begin
                if (out_idx < exp_d.size()) begin
                    chk($sformatf("%s_data%0d", tn, out_idx), out_data, exp_d[out_idx]);
                    chk($sformatf("%s_bytes%0d", tn, out_idx), {29'h0, out_bytes}, {29'h0, exp_b[out_idx]});
                    chk($sformatf("%s_last%0d", tn, out_idx), {31'h0, out_last}, {31'h0, exp_l[out_idx]});
                end
                out_idx++;
            end
            @(negedge wb_clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tn, "_completed"}, {31'h0, fin}, 32'h1);
        chk({tn, "_in_words"}, in_idx, exp_in);
        chk({tn, "_out_words"}, out_idx, exp_d.size());
        chk({tn, "_done_cnt"}, done_cnt, 1);
        #1;
        chk({tn, "_done_pulse_end"}, {31'h0, done}, 32'h0);
        chk({tn, "_busy_end"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic set_exp(input logic [31:0] d, input logic [2:0] b, input logic l);
        exp_d.push_back(d);
        exp_b.push_back(b);
        exp_l.push_back(l);
    endtask

    task automatic clear_vecs();
        in_words.delete();
        exp_d.delete();
        exp_b.delete();
        exp_l.delete();
    endtask

    task automatic load_t4();
        clear_vecs();
        for (int w = 0; w < 6; w++)
            in_words.push_back({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
        set_exp(32'h0102_0304, 3'd4, 1'b0);
        set_exp(32'h0506_0708, 3'd4, 1'b0);
        set_exp(32'h090A_0B0C, 3'd4, 1'b0);
        set_exp(32'h0D0E_0F10, 3'd4, 1'b0);
        set_exp(32'h1112_1300, 3'd3, 1'b1);
    endtask

    task automatic load_t3();
        clear_vecs();
        in_words.push_back(32'h0001_0203);
        in_words.push_back(32'h0405_0607);
        in_words.push_back(32'h0809_0A0B);
        set_exp(32'h0102_0304, 3'd4, 1'b0);
        set_exp(32'h0506_0708, 3'd4, 1'b1);
    endtask

    task automatic load_t1();
        clear_vecs();
        in_words.push_back(32'hAABB_CCDD);
        in_words.push_back(32'hEEEE_EEEE);
        set_exp(32'hAA00_0000, 3'd1, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_adr_i = 32'h0;
        xfersize   = '0;
        in_data    = 32'h0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(negedge wb_clk);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_busy_done", {30'h0, busy, done}, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h0);
        rst = 1'b0;

        // T1: aligned single byte, garbage lanes must be discarded
        load_t1();
        run_xfer("t1", 32'd4, 1, 1, 0);

        // T2: window straddles a word boundary
        clear_vecs();
        in_words.push_back(32'h1122_3344);
        in_words.push_back(32'h5566_7788);
        set_exp(32'h4455_0000, 3'd2, 1'b1);
        run_xfer("t2", 32'd11, 2, 2, 0);

        // T3: offset 1, exactly two full outputs
        load_t3();
        run_xfer("t3", 32'd85, 8, 3, 0);

        // T4: offset 1, 19 bytes ends with a flush of 3 bytes; 6th word must not be taken
        load_t4();
        run_xfer("t4", 32'd101, 19, 5, 0);

        // T5: T3 with five stalled cycles on the first output
        load_t3();
        run_xfer("t5", 32'd85, 8, 3, 5);

        // T6: zero-length transfer
        @(negedge wb_clk);
        in_valid   = 1'b1;
        in_data    = 32'h1234_5678;
        start      = 1'b1;
        base_adr_i = 32'd2;
        xfersize   = '0;
        #1;
        chk("t6_in_ready_c0", {31'h0, in_ready}, 32'h0);
        @(negedge wb_clk);
        start = 1'b0;
        #1;
        chk("t6_done", {31'h0, done}, 32'h1);
        chk("t6_in_ready_c1", {31'h0, in_ready}, 32'h0);
        chk("t6_out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge wb_clk);
        #1;
        chk("t6_done_off", {31'h0, done}, 32'h0);
        chk("t6_in_ready_c2", {31'h0, in_ready}, 32'h0);
        in_valid = 1'b0;

        // Reset in the middle of T4
        load_t4();
        @(negedge wb_clk);
        start      = 1'b1;
        base_adr_i = 32'd101;
        xfersize   = XW'(19);
        out_ready  = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        begin
            int idx = 0;
            for (int c = 0; c < 3; c++) begin
                in_valid = 1'b1;
                in_data  = in_words[idx];
                #1;
                if (in_ready)
                    idx++;
                @(negedge wb_clk);
            end
        end
        chk("rst_mid_busy_before", {31'h0, busy}, 32'h1);
        #2;
        rst = 1'b1;
        @(posedge wb_clk);
        #1;
        chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid_out_data", out_data, 32'h0);
        chk("rst_mid_bytes_last", {28'h0, out_bytes, out_last}, 32'h0);
        chk("rst_mid_busy_done", {30'h0, busy, done}, 32'h0);
        chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge wb_clk);
        rst = 1'b0;
        begin
            int dcnt = 0;
            for (int c = 0; c < 5; c++) begin
                #1;
                if (done)
                    dcnt++;
                @(negedge wb_clk);
            end
            chk("rst_mid_no_done", dcnt, 0);
        end
        in_valid = 1'b0;

        load_t1();
        run_xfer("t1_after_rst", 32'd4, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
